// File: rtl/eth_pkg.sv
// Shared encodings and constants for the 10BASE-T Manchester transmitter.
package eth_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StFcs,
    StSoi,
    StIpg
  } tx_state_e;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/eth_crc32_serial.sv
// Bit-serial CRC-32 (MSB-feedback form); one bit absorbed per enabled clock.
module eth_crc32_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [31:0] crc
);
  import eth_pkg::*;

  logic [31:0] crc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else if (init) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= {crc_q[30:0], 1'b0} ^ ({32{din ^ crc_q[31]}} & CRC_POLY);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/eth_tx_mac10.sv
// 10BASE-T Manchester frame transmitter: preamble, SFD, BRAM payload, zero pad, FCS, TP_IDL, IPG.
// All state advances only on clk_stb (one half-bit); link pulses are sent while idle.
module eth_tx_mac10 #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned PRE_BYTES  = 7,
  parameter int unsigned SOI_HB     = 6,
  parameter int unsigned IPG_HB     = 192,
  parameter int unsigned NLP_PERIOD = 320000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_stb,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_p,
  output logic              tx_n,
  output logic              busy,
  output logic              done
);
  import eth_pkg::*;

  localparam int unsigned CntW = (ADDR_W + 5 > 16) ? ADDR_W + 5 : 16;
  localparam int unsigned NlpW = $clog2(NLP_PERIOD + 2);
  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] MinLen = (ADDR_W + 1)'(MIN_LEN);

  tx_state_e       state_q, state_d, after_data;
  logic [CntW-1:0] n_q, limit;
  logic [ADDR_W:0] len_q, fetch_q;
  logic [NlpW-1:0] nlp_q;
  logic [7:0]      byte_q;
  logic [31:0]     crc;
  logic            done_q, last, fetch_win, capture, nlp_hit, bit_val, crc_en, crc_din;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (clk_stb) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    limit = '0;
    unique case (state_q)
      StPreamble: limit = CntW'(PRE_BYTES * 16);
      StSfd:      limit = CntW'(16);
      StData:     limit = CntW'({len_q, 4'h0});
      StPad:      limit = CntW'({MinLen - len_q, 4'h0});
      StFcs:      limit = CntW'(64);
      StSoi:      limit = CntW'(SOI_HB);
      StIpg:      limit = CntW'(IPG_HB);
      default:    limit = '0;
    endcase
  end

  assign last    = (n_q == limit - CntW'(1));
  assign nlp_hit = (nlp_q == NlpW'(NLP_PERIOD));

  always_comb begin
    state_d    = state_q;
    after_data = (len_q < MinLen) ? StPad : StFcs;
    if (clk_stb) begin
      unique case (state_q)
        StIdle:     if (start) state_d = StPreamble;
        StPreamble: if (last) state_d = StSfd;
        StSfd:      if (last) state_d = (len_q != '0) ? StData : after_data;
        StData:     if (last) state_d = after_data;
        StPad:      if (last) state_d = StFcs;
        StFcs:      if (last) state_d = StSoi;
        StSoi:      if (last) state_d = StIpg;
        StIpg:      if (last) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Byte k is fetched during slot k-1 (SFD for byte 0) and lands in byte_q at that slot's end.
  assign fetch_win = ((state_q == StSfd) || (state_q == StData)) && (fetch_q < len_q);
  assign rd_en     = clk_stb && fetch_win && (n_q[3:0] == 4'd13);
  assign capture   = clk_stb && fetch_win && (n_q[3:0] == 4'd15);
  assign rd_addr   = fetch_q[ADDR_W] ? '1 : fetch_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q     <= '0;
      len_q   <= '0;
      fetch_q <= '0;
      nlp_q   <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= clk_stb && (state_q == StIpg) && last;
      if (clk_stb) begin
        n_q <= ((state_d != state_q) || (state_q == StIdle)) ? '0 : n_q + CntW'(1);
        if (state_q == StIdle) begin
          nlp_q <= (start || nlp_hit) ? '0 : nlp_q + NlpW'(1);
          if (start) begin
            len_q   <= (len > MaxLen) ? MaxLen : len;
            fetch_q <= '0;
          end
        end else begin
          nlp_q <= '0;
        end
        if (capture) begin
          byte_q  <= rd_data;
          fetch_q <= fetch_q + (ADDR_W + 1)'(1);
        end
      end
    end
  end

  // In FCS, feeding crc[31] back cancels the polynomial term, leaving a plain left shift.
  assign crc_en  = clk_stb && n_q[0] && (state_q inside {StData, StPad, StFcs});
  assign crc_din = (state_q == StFcs) ? crc[31] : bit_val;

  eth_crc32_serial u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .init (clk_stb && (state_q == StPreamble)),
    .en   (crc_en),
    .din  (crc_din),
    .crc  (crc)
  );

  always_comb begin
    bit_val = 1'b0;
    tx_p    = 1'b0;
    tx_n    = 1'b0;
    unique case (state_q)
      StPreamble: bit_val = PREAMBLE_BYTE[n_q[3:1]];
      StSfd:      bit_val = SFD_BYTE[n_q[3:1]];
      StData:     bit_val = byte_q[n_q[3:1]];
      StFcs:      bit_val = ~crc[31];
      default:    bit_val = 1'b0;
    endcase
    unique case (state_q)
      StIdle: tx_p = nlp_hit && !(clk_stb && start);
      StPreamble, StSfd, StData, StPad, StFcs: begin
        tx_p = n_q[0] ? bit_val : ~bit_val;
        tx_n = ~tx_p;
      end
      StSoi:   tx_p = 1'b1;
      default: tx_p = 1'b0;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_eth_tx_mac10.sv
// Randomised frame bench for eth_tx_mac10 against a byte-level frame and reflected CRC-32 model.
module tb_eth_tx_mac10;
  localparam int unsigned AW   = 6;
  localparam int unsigned MINL = 20;
  localparam int unsigned PRE  = 7;
  localparam int unsigned SOI  = 6;
  localparam int unsigned IPG  = 192;
  localparam int unsigned NLP  = 300;
  localparam int          MAXL = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_stb = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          tx_p, tx_n, busy, done;

  logic [7:0] mem [MAXL];
  logic [1:0] wire_q[$];
  logic [1:0] exp_q[$];
  int         addr_q[$];
  int         nlp_pos[$];
  int         done_cnt = 0;
  int         idle_idx = 0;
  int         checks = 0;
  int         failures = 0;

  eth_tx_mac10 #(
    .ADDR_W    (AW),
    .MIN_LEN   (MINL),
    .PRE_BYTES (PRE),
    .SOI_HB    (SOI),
    .IPG_HB    (IPG),
    .NLP_PERIOD(NLP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_stb(clk_stb),
    .start  (start),
    .len    (len),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tx_p   (tx_p),
    .tx_n   (tx_n),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clk_stb <= ~clk_stb;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // One sample per strobe period, taken mid-clock.
  always @(negedge clk) begin
    if (!rst_n) begin
      idle_idx = 0;
    end else begin
      if (done) done_cnt++;
      if (clk_stb) begin
        if (busy) begin
          wire_q.push_back({tx_p, tx_n});
          idle_idx = 0;
        end else begin
          if (tx_p) nlp_pos.push_back(idle_idx);
          idle_idx++;
        end
        if (rd_en) addr_q.push_back(int'(rd_addr));
      end
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Standard reflected Ethernet CRC; returns the FCS value whose bytes go out little-endian.
  function automatic logic [31:0] fcs_ref(input logic [7:0] b[$]);
    logic [31:0] r = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      r ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return ~r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({~b[i], b[i]});
      exp_q.push_back({b[i], ~b[i]});
    end
  endtask

  task automatic run_frame(input int req_len, input bit hold, input bit sync_nlp, input string tag);
    int          n_eff;
    int          waited;
    int          mism;
    logic [7:0]  body[$];
    logic [31:0] fcs;
    n_eff = (req_len > MAXL) ? MAXL : req_len;
    body = {};
    for (int i = 0; i < n_eff; i++) body.push_back(mem[i]);
    while (body.size() < MINL) body.push_back(8'h00);
    fcs = fcs_ref(body);
    exp_q = {};
    for (int i = 0; i < int'(PRE); i++) push_byte(8'h55);
    push_byte(8'hD5);
    foreach (body[i]) push_byte(body[i]);
    for (int i = 0; i < 4; i++) push_byte(fcs[8*i +: 8]);
    for (int i = 0; i < int'(SOI); i++) exp_q.push_back(2'b10);
    for (int i = 0; i < int'(IPG); i++) exp_q.push_back(2'b00);

    @(posedge clk); #1;
    if (sync_nlp) begin
      nlp_pos = {};
      waited = 0;
      while (!(clk_stb && idle_idx == int'(NLP)) && waited < 2000) begin
        @(posedge clk); #1;
        waited++;
      end
      check_eq({tag, "_sync"}, idle_idx, NLP);
    end
    wire_q = {};
    addr_q = {};
    done_cnt = 0;
    len = (AW + 1)'(req_len);
    start = 1'b1;
    waited = 0;
    while (!busy && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, "_accept"}, busy, 1);
    if (sync_nlp) check_eq({tag, "_no_nlp"}, nlp_pos.size(), 0);
    if (!hold) start = 1'b0;
    waited = 0;
    while (busy && waited < 6000) begin
      @(posedge clk); #1;
      waited++;
    end
    start = 1'b0;
    check_eq({tag, "_end"}, busy, 0);
    repeat (6) @(posedge clk);
    #1;
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_strobes"}, wire_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < wire_q.size() && i < exp_q.size(); i++)
      if (wire_q[i] != exp_q[i]) mism++;
    check_eq({tag, "_wire"}, mism, 0);
    check_eq({tag, "_reads"}, addr_q.size(), n_eff);
    mism = 0;
    foreach (addr_q[i]) if (addr_q[i] != i) mism++;
    check_eq({tag, "_addr"}, mism, 0);
    check_eq({tag, "_done"}, done_cnt, 1);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < MAXL; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    logic [71:0] digits;
    int          waited;
    randomize_mem();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_tx_p", tx_p, 0);
    check_eq("rst_tx_n", tx_n, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;

    digits = "123456789";
    for (int i = 0; i < 9; i++) mem[i] = digits[71-8*i -: 8];
    run_frame(9, 1'b0, 1'b0, "crc9");
    randomize_mem();
    run_frame(10, 1'b0, 1'b0, "pad10");
    run_frame(0, 1'b0, 1'b0, "zero");
    randomize_mem();
    run_frame(MINL, 1'b0, 1'b0, "min");

    nlp_pos = {};
    repeat (2 * (3 * (NLP + 1) + 4)) @(posedge clk);
    #1;
    check_eq("nlp_count", nlp_pos.size(), 3);
    for (int i = 0; i < 3; i++)
      check_eq("nlp_pos", (i < nlp_pos.size()) ? nlp_pos[i] : -1, i * (NLP + 1) + NLP);

    randomize_mem();
    run_frame(MAXL + 5, 1'b0, 1'b0, "clamp");
    randomize_mem();
    run_frame(5, 1'b0, 1'b1, "nlp_start");
    run_frame(12, 1'b1, 1'b0, "held");

    randomize_mem();
    @(posedge clk); #1;
    len = (AW + 1)'(40);
    start = 1'b1;
    waited = 0;
    while (!busy && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    start = 1'b0;
    waited = 0;
    while (rd_addr != (AW)'(21) && waited < 4000) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("mid_reached", rd_addr, 21);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_tx_p", tx_p, 0);
    check_eq("mid_tx_n", tx_n, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_rd_addr", rd_addr, 0);
    rst_n = 1'b1;
    run_frame(33, 1'b0, 1'b0, "post_rst");

    for (int f = 0; f < 6; f++) begin
      randomize_mem();
      run_frame(int'($urandom_range(0, MAXL + 10)), 1'b0, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
